m_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous 4K-word RAM (1-cycle read latency, write on posedge)

---
 rtl/m_mem_arbiter_pkg.sv | 15 +
 rtl/m_mem_arbiter_if.sv | 33 +++
 rtl/m_arb_prio2.sv | 46 ++++
 rtl/m_mem_arbiter.sv | 85 ++++++++
 tb/tb_m_mem_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/m_mem_arbiter_pkg.sv
// Shared widths and owner encoding for the unified-memory arbiter.
// Imported by the interface, the priority sub-module and the top.
package m_mem_arbiter_pkg;

    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/m_mem_arbiter_if.sv
// Core-side fetch/data ports plus the single-port RAM bus for m_mem_arbiter.
// slave = arbiter view, master = core + RAM view.
interface m_mem_arbiter_if;
    import m_mem_arbiter_pkg::*;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_din;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_dout;
    logic          r_stall;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_din, m_dout,
        output i_gnt, i_rvalid, d_gnt, d_rvalid, r_rdata, m_addr, m_we, m_din, r_stall
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_din, m_dout,
        input  i_gnt, i_rvalid, d_gnt, d_rvalid, r_rdata, m_addr, m_we, m_din, r_stall
    );

endinterface

// File: rtl/m_arb_prio2.sv
// Two-way fixed-priority arbiter (D wins) with a saturating counter that
// forces I to win the next conflict after MAX_WAIT consecutive denials.
module m_arb_prio2
    import m_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              i_req_i,
    input  logic              d_req_i,
    output logic              i_gnt_o,
    output logic              d_gnt_o,
    output logic [WAIT_W-1:0] wait_o
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              force_i;

    assign force_i = (wait_q == WAIT_MAX);

    // Grants are masked during reset so no RAM access escapes while rst_n is low.
    assign i_gnt_o = w_rst_n & i_req_i & (~d_req_i | force_i);
    assign d_gnt_o = w_rst_n & d_req_i & ~(i_req_i & force_i);
    assign wait_o  = wait_q;

    always_comb begin
        wait_d = wait_q;
        if (!i_req_i || i_gnt_o) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/m_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (I) and data (D).
// Does the RAM mux, the read-owner tag and store-to-load forwarding.
module m_mem_arbiter
    import m_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input logic             w_clk,
    input logic             w_rst_n,
    m_mem_arbiter_if.slave  bus
);

    logic              i_gnt, d_gnt, rd_gnt, fwd_hit;
    logic [WAIT_W-1:0] r_wait;
    logic [AW-1:0]     mem_addr;
    owner_t            owner_q, owner_d;
    logic [AW-1:0]     addr_q;
    logic              st_vld_q, fwd_q;
    logic [AW-1:0]     st_addr_q;
    logic [DW-1:0]     st_data_q, fwd_data_q;

    m_arb_prio2 #(.MAX_WAIT(MAX_WAIT)) u_prio (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .i_req_i (bus.i_req),
        .d_req_i (bus.d_req),
        .i_gnt_o (i_gnt),
        .d_gnt_o (d_gnt),
        .wait_o  (r_wait)
    );

    assign rd_gnt = i_gnt | (d_gnt & ~bus.d_we);

    always_comb begin
        mem_addr = addr_q;
        if (i_gnt) begin
            mem_addr = bus.i_addr;
        end else if (d_gnt) begin
            mem_addr = bus.d_addr;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (i_gnt) begin
            owner_d = OWN_I;
        end else if (d_gnt && !bus.d_we) begin
            owner_d = OWN_D;
        end
    end

    // A read of the word stored in the previous cycle must not rely on RAM write-first behaviour.
    assign fwd_hit = rd_gnt & st_vld_q & (st_addr_q == mem_addr);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            owner_q  <= OWN_NONE;
            addr_q   <= '0;
            st_vld_q <= 1'b0;
            fwd_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            addr_q   <= mem_addr;
            st_vld_q <= d_gnt & bus.d_we;
            fwd_q    <= fwd_hit;
        end
    end

    always_ff @(posedge w_clk) begin
        st_addr_q  <= bus.d_addr;
        st_data_q  <= bus.d_din;
        fwd_data_q <= st_data_q;
    end

    assign bus.i_gnt    = i_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.i_rvalid = (owner_q == OWN_I);
    assign bus.d_rvalid = (owner_q == OWN_D);
    assign bus.r_rdata  = fwd_q ? fwd_data_q : bus.m_dout;
    assign bus.m_addr   = mem_addr;
    assign bus.m_we     = d_gnt & bus.d_we;
    assign bus.m_din    = d_gnt ? bus.d_din : '0;
    assign bus.r_stall  = (bus.i_req & ~i_gnt) | (bus.d_req & ~d_gnt);

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter with a behavioural 4K-word read-old-data RAM.
module tb_m_mem_arbiter;
    import m_mem_arbiter_pkg::*;

    logic w_clk   = 1'b0;
    logic w_rst_n = 1'b0;
    always #5 w_clk = ~w_clk;

    m_mem_arbiter_if bus ();

    m_mem_arbiter #(.MAX_WAIT(4)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always @(posedge w_clk) begin
        if (bus.m_we) ram[bus.m_addr] <= bus.m_din;
        bus.m_dout <= ram[bus.m_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_init(input int a);
        return (a == 5) ? 32'h2014_000B : (32'hA000_0000 | 32'(a));
    endfunction

    task automatic next_cyc();
        @(posedge w_clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcount;
        int exp_w [6];
        exp_w = '{1, 2, 3, 4, 0, 1};
        for (int i = 0; i < (1 << AW); i++) ram[i] = mem_init(i);
        bus.i_addr = '0;
        bus.d_addr = '0;
        bus.d_din  = '0;

        // Reset held with both ports requesting, including a store attempt
        bus.i_req = 1'b1; bus.i_addr = 12'd7;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'd3; bus.d_din = 32'hFFFF_FFFF;
        #2;
        check_eq("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
        check_eq("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        check_eq("rst_m_we", 32'(bus.m_we), 32'd0);
        check_eq("rst_m_addr", 32'(bus.m_addr), 32'd0);
        check_eq("rst_m_din", bus.m_din, 32'd0);
        next_cyc();
        check_eq("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        check_eq("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check_eq("rst_r_wait", 32'(dut.r_wait), 32'd0);
        check_eq("rst_ram3", ram[3], mem_init(3));
        idle();
        w_rst_n = 1'b1;
        next_cyc();

        // I alone
        bus.i_req = 1'b1; bus.i_addr = 12'd5;
        #3;
        check_eq("ialone_gnt", 32'(bus.i_gnt), 32'd1);
        check_eq("ialone_dgnt", 32'(bus.d_gnt), 32'd0);
        check_eq("ialone_stall", 32'(bus.r_stall), 32'd0);
        check_eq("ialone_maddr", 32'(bus.m_addr), 32'd5);
        next_cyc();
        check_eq("ialone_rvalid", 32'(bus.i_rvalid), 32'd1);
        check_eq("ialone_drvalid", 32'(bus.d_rvalid), 32'd0);
        check_eq("ialone_rdata", bus.r_rdata, 32'h2014_000B);

        gcount = 0;
        for (int k = 0; k < 8; k++) begin
            bus.i_addr = 12'(k);
            #3;
            check_eq("fetch_gnt", 32'(bus.i_gnt), 32'd1);
            gcount += int'(bus.i_gnt);
            next_cyc();
            check_eq("fetch_rvalid", 32'(bus.i_rvalid), 32'd1);
            check_eq("fetch_rdata", bus.r_rdata, mem_init(k));
        end
        check_eq("fetch_count", 32'(gcount), 32'd8);
        idle();
        next_cyc();
        check_eq("idle_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        check_eq("idle_maddr_hold", 32'(bus.m_addr), 32'd7);

        // Conflict: D wins four times, then I is forced through
        bus.i_req = 1'b1; bus.i_addr = 12'd1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'd2;
        for (int c = 0; c < 6; c++) begin
            #3;
            check_eq("conf_i_gnt", 32'(bus.i_gnt), (c == 4) ? 32'd1 : 32'd0);
            check_eq("conf_d_gnt", 32'(bus.d_gnt), (c == 4) ? 32'd0 : 32'd1);
            check_eq("conf_stall", 32'(bus.r_stall), 32'd1);
            check_eq("conf_maddr", 32'(bus.m_addr), (c == 4) ? 32'd1 : 32'd2);
            check_eq("conf_mutex", 32'(bus.i_gnt & bus.d_gnt), 32'd0);
            next_cyc();
            check_eq("conf_r_wait", 32'(dut.r_wait), 32'(exp_w[c]));
            check_eq("conf_i_rvalid", 32'(bus.i_rvalid), (c == 4) ? 32'd1 : 32'd0);
            check_eq("conf_rdata", bus.r_rdata, (c == 4) ? mem_init(1) : mem_init(2));
        end
        idle();
        next_cyc();
        check_eq("conf_wait_clr", 32'(dut.r_wait), 32'd0);

        // Store then load of the same word
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'd9; bus.d_din = 32'h0000_DEAD;
        #3;
        check_eq("st_d_gnt", 32'(bus.d_gnt), 32'd1);
        check_eq("st_m_we", 32'(bus.m_we), 32'd1);
        check_eq("st_m_din", bus.m_din, 32'h0000_DEAD);
        check_eq("st_m_addr", 32'(bus.m_addr), 32'd9);
        next_cyc();
        check_eq("st_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        bus.d_we = 1'b0; bus.d_din = 32'h1111_1111;
        #3;
        check_eq("ld_m_we", 32'(bus.m_we), 32'd0);
        check_eq("ld_d_gnt", 32'(bus.d_gnt), 32'd1);
        next_cyc();
        check_eq("ld_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check_eq("ld_rdata", bus.r_rdata, 32'h0000_DEAD);
        idle();

        // Cancel: I denied once, then drops its request
        bus.i_req = 1'b1; bus.i_addr = 12'd3;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'd4;
        #3;
        check_eq("cxl_i_gnt", 32'(bus.i_gnt), 32'd0);
        check_eq("cxl_stall", 32'(bus.r_stall), 32'd1);
        next_cyc();
        check_eq("cxl_wait1", 32'(dut.r_wait), 32'd1);
        check_eq("cxl_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check_eq("cxl_i_rvalid0", 32'(bus.i_rvalid), 32'd0);
        idle();
        #3;
        check_eq("cxl_stall_off", 32'(bus.r_stall), 32'd0);
        next_cyc();
        check_eq("cxl_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        check_eq("cxl_wait0", 32'(dut.r_wait), 32'd0);

        // Async reset between load grant and its data; a store attempt during reset must not land
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'd5;
        #3;
        check_eq("ar_d_gnt", 32'(bus.d_gnt), 32'd1);
        w_rst_n = 1'b0;
        bus.d_we = 1'b1; bus.d_din = 32'hBAD0_BAD0;
        #1;
        check_eq("ar_d_gnt_rst", 32'(bus.d_gnt), 32'd0);
        check_eq("ar_m_we", 32'(bus.m_we), 32'd0);
        next_cyc();
        check_eq("ar_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check_eq("ar_ram5", ram[5], 32'h2014_000B);
        idle();
        w_rst_n = 1'b1;
        next_cyc();
        check_eq("ar_d_rvalid_post", 32'(bus.d_rvalid), 32'd0);
        bus.i_req = 1'b1; bus.i_addr = 12'd5;
        #3;
        check_eq("ar_fetch_gnt", 32'(bus.i_gnt), 32'd1);
        next_cyc();
        check_eq("ar_fetch_rvalid", 32'(bus.i_rvalid), 32'd1);
        check_eq("ar_fetch_rdata", bus.r_rdata, 32'h2014_000B);
        idle();
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
